// File: rtl/seg_pkg.sv
// seg_pkg: shared definitions for the seven-segment scan driver.
//   HEX_SEG   : nibble -> active-low g..a segment pattern
//   SEG_OFF   : all cathodes dark (active-low), including dp
//   AN_OFF    : all anodes off (active-low)
//   scan_state_t : scan FSM states
//   disp_t    : one display image (value, decimal points, digit enables)
package seg_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam logic [3:0] AN_OFF  = 4'hF;

    // Bit order is {g,f,e,d,c,b,a}, 0 = segment lit.
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  digit_en;
    } disp_t;

endpackage

// File: rtl/seg_scan_hex_seg_lut.sv
// hex_seg_lut: combinational hex nibble to seven-segment decoder.
//   nibble : 4-bit hex digit
//   seg    : active-low segment pattern, [6:0] = g..a
module hex_seg_lut
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for a 4-digit common-anode
// seven-segment display.
//   clk, rst_n : clock, asynchronous active-low reset
//   value      : 16-bit hex value, [3:0] is digit 0 (rightmost)
//   dp         : per-digit decimal point request, active-high
//   digit_en   : per-digit enable, active-high
//   load       : one-cycle strobe capturing value/dp/digit_en as pending
//   seg_cat    : cathodes, active-low, [6:0] = g..a, [7] = dp
//   seg_an     : anodes, active-low, one-hot-low while a digit is lit
//   frame_done : one-cycle pulse in the cycle the last digit slot ends
//
// Each digit slot is BLANK_CYCLES of all-dark (anti-ghosting) followed by
// DIGIT_CYCLES of the digit lit. New images are staged in a pending
// register and only promoted to the displayed image at the frame boundary,
// so a frame never mixes two images.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int NUM_DIGITS   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] value,
    input  logic [3:0]  dp,
    input  logic [3:0]  digit_en,
    input  logic        load,
    output logic [7:0]  seg_cat,
    output logic [3:0]  seg_an,
    output logic        frame_done
);

    localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);
    localparam int IW = $clog2(NUM_DIGITS);

    localparam logic [CW-1:0] DIGIT_LAST = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
    // With no blank interval the FSM never leaves SHOW.
    localparam scan_state_t   SLOT_START = (BLANK_CYCLES == 0) ? SHOW : BLANK;

    scan_state_t   state, state_nx;
    logic [IW-1:0] idx, idx_nx;
    logic [CW-1:0] cnt, cnt_nx;
    disp_t         active, pending, incoming;
    logic          pending_valid;
    logic          boundary, boundary_nx;
    logic [6:0]    seg_pat;
    logic          lit;

    assign incoming = '{value: value, dp: dp, digit_en: digit_en};

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        cnt_nx   = cnt + 1'b1;
        if (state == BLANK) begin
            if (cnt == BLANK_LAST) begin
                state_nx = SHOW;
                cnt_nx   = '0;
            end
        end else begin
            if (cnt == DIGIT_LAST) begin
                state_nx = SLOT_START;
                idx_nx   = (idx == LAST_IDX) ? '0 : idx + 1'b1;
                cnt_nx   = '0;
            end
        end
    end

    // boundary: this cycle ends the last digit slot.
    // boundary_nx: the next cycle will; registering it lets frame_done be a
    // flop that is high exactly during the boundary cycle.
    assign boundary    = (state == SHOW) && (cnt == DIGIT_LAST) && (idx == LAST_IDX);
    assign boundary_nx = (state_nx == SHOW) && (cnt_nx == DIGIT_LAST) && (idx_nx == LAST_IDX);

    hex_seg_lut u_lut (
        .nibble (active.value[{idx, 2'b00} +: 4]),
        .seg    (seg_pat)
    );

    assign lit = (state == SHOW) && active.digit_en[idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= SLOT_START;
            idx           <= '0;
            cnt           <= '0;
            active        <= '0;
            pending       <= '0;
            pending_valid <= 1'b0;
            seg_an        <= AN_OFF;
            seg_cat       <= SEG_OFF;
            frame_done    <= 1'b0;
        end else begin
            state      <= state_nx;
            idx        <= idx_nx;
            cnt        <= cnt_nx;
            frame_done <= boundary_nx;

            if (lit) begin
                seg_an  <= ~(4'b0001 << idx);
                seg_cat <= {~active.dp[idx], seg_pat};
            end else begin
                seg_an  <= AN_OFF;
                seg_cat <= SEG_OFF;
            end

            // A load coinciding with the boundary bypasses pending so it is
            // neither lost nor shown a frame late.
            if (load) begin
                pending <= incoming;
            end
            if (boundary) begin
                pending_valid <= 1'b0;
                if (load) begin
                    active <= incoming;
                end else if (pending_valid) begin
                    active <= pending;
                end
            end else if (load) begin
                pending_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: directed bench for seg_scan_driver with
// DIGIT_CYCLES=4, BLANK_CYCLES=2 (6-cycle slots, 24-cycle frames).
module tb_seg_scan_driver;

    logic        clk;
    logic        rst_n;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic        load;
    logic [7:0]  seg_cat;
    logic [3:0]  seg_an;
    logic        frame_done;

    int checks = 0;
    int errors = 0;

    seg_scan_driver #(
        .DIGIT_CYCLES (4),
        .BLANK_CYCLES (2),
        .NUM_DIGITS   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .dp         (dp),
        .digit_en   (digit_en),
        .load       (load),
        .seg_cat    (seg_cat),
        .seg_an     (seg_an),
        .frame_done (frame_done)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vectors ----------------
    // an_exp / cat_exp hold the lit-phase pins for digit slots 3..0
    // (slot 0 in the low bits); disabled digits are F / FF.
    typedef struct packed {
        logic [15:0] value;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [15:0] an_exp;
        logic [31:0] cat_exp;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs [NV];

    // ---------------- expectation state ----------------
    int tcnt    = 0;   // clock edges since reset release
    int act_id  = -1;  // image shown this frame (-1 = cleared)
    int pend_id = -1;
    bit pend_v  = 1'b0;
    int ld_id   = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at t=%0d: got %h expected %h", name, tcnt, act, exp);
        end
    endtask

    // One clock: derive the pins expected after the edge from the slot
    // position before it, apply the edge, then compare.
    task automatic step();
        int p;
        int s;
        logic [3:0] ea;
        logic [7:0] ec;
        logic       ef;
        p  = tcnt % 24;
        s  = p / 6;
        ea = 4'hF;
        ec = 8'hFF;
        if ((p % 6) >= 2 && act_id >= 0) begin
            ea = vecs[act_id].an_exp[4*s +: 4];
            ec = vecs[act_id].cat_exp[8*s +: 8];
        end
        ef = (((tcnt + 1) % 24) == 23);
        if (p == 23) begin
            if (load) begin
                act_id = ld_id;
                pend_v = 1'b0;
            end else if (pend_v) begin
                act_id = pend_id;
                pend_v = 1'b0;
            end
        end else if (load) begin
            pend_id = ld_id;
            pend_v  = 1'b1;
        end
        @(posedge clk);
        #1;
        tcnt++;
        chk("seg_an", {28'd0, seg_an}, {28'd0, ea});
        chk("seg_cat", {24'd0, seg_cat}, {24'd0, ec});
        chk("frame_done", {31'd0, frame_done}, {31'd0, ef});
    endtask

    task automatic do_load(input int id);
        value    = vecs[id].value;
        dp       = vecs[id].dp;
        digit_en = vecs[id].en;
        ld_id    = id;
        load     = 1'b1;
        step();
        load     = 1'b0;
    endtask

    // Bounded by 24 steps since tcnt advances every step.
    task automatic wait_until(input int r);
        while ((tcnt % 24) != r) step();
    endtask

    task automatic run_frame();
        for (int k = 0; k < 24; k++) step();
    endtask

    initial begin
        vecs[0] = '{16'h1234, 4'h0, 4'hF, 16'h7BDE, 32'hF9A4B099};
        vecs[1] = '{16'hABCD, 4'h1, 4'h5, 16'hFBFE, 32'hFF83FF21};
        vecs[2] = '{16'h5678, 4'hA, 4'hF, 16'h7BDE, 32'h12827880};
        vecs[3] = '{16'h90EF, 4'hF, 4'hE, 16'h7BDF, 32'h104006FF};
        vecs[4] = '{16'hCBA0, 4'h0, 4'hF, 16'h7BDE, 32'hA78388C0};
        vecs[5] = '{16'h0000, 4'h0, 4'hF, 16'h7BDE, 32'hC0C0C0C0};
        vecs[6] = '{16'h8888, 4'h0, 4'hF, 16'h7BDE, 32'h80808080};
        vecs[7] = '{16'hFFFF, 4'h0, 4'hF, 16'h7BDE, 32'h8E8E8E8E};

        rst_n    = 1'b0;
        value    = '0;
        dp       = '0;
        digit_en = '0;
        load     = 1'b0;

        // Held in reset: pins dark, no frame_done.
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("reset_an", {28'd0, seg_an}, 32'h0000000F);
            chk("reset_cat", {24'd0, seg_cat}, 32'h000000FF);
            chk("reset_fd", {31'd0, frame_done}, 32'd0);
        end
        rst_n = 1'b1;
        tcnt  = 0;

        // Idle: never loaded, so dark, with frame_done every 24 cycles.
        run_frame();
        run_frame();

        // Table: load mid-frame, then check the whole following frame.
        for (int i = 0; i < 5; i++) begin
            wait_until(5);
            do_load(i);
            wait_until(0);
            run_frame();
        end

        // Tear-free: two loads in one frame; the frame keeps showing the
        // old image, the next shows only the last load.
        wait_until(5);
        do_load(5);
        wait_until(15);
        do_load(6);
        wait_until(0);
        run_frame();

        // Load in the frame_done cycle goes straight to the next frame.
        wait_until(23);
        do_load(7);
        chk("pending_valid", {31'd0, dut.pending_valid}, 32'd0);
        run_frame();
        chk("pending_valid_later", {31'd0, dut.pending_valid}, 32'd0);
        run_frame();

        // Asynchronous reset while digit 2 is lit.
        wait_until(16);
        chk("digit2_lit_an", {28'd0, seg_an}, 32'h0000000B);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_an", {28'd0, seg_an}, 32'h0000000F);
        chk("async_rst_cat", {24'd0, seg_cat}, 32'h000000FF);
        chk("async_rst_fd", {31'd0, frame_done}, 32'd0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        tcnt    = 0;
        act_id  = -1;
        pend_v  = 1'b0;
        pend_id = -1;

        // Restart: cleared image stays dark, then a new load scans from digit 0.
        run_frame();
        wait_until(5);
        do_load(0);
        wait_until(0);
        run_frame();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
